// File: rtl/map_tile_writer_pkg.sv
// Shared constants, tile ids, FSM encoding and request payload for the tile-map writer.
package map_pkg;

  localparam int unsigned MAP_ROWS = 14;
  localparam int unsigned MAP_COLS = 212;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned ID_W     = 6;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned ERR_W    = 8;

  localparam logic [ID_W-1:0] TILE_SKY         = ID_W'(0);
  localparam logic [ID_W-1:0] TILE_BRICK       = ID_W'(1);
  localparam logic [ID_W-1:0] TILE_QBLOCK      = ID_W'(2);
  localparam logic [ID_W-1:0] TILE_USED_QBLOCK = ID_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ID_W-1:0]  id;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  // 212*row + col as shift-add: 212 = 128 + 64 + 16 + 4
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 6) + (r << 4) + (r << 2) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/map_tile_writer_if.sv
// Request, fill-command and map-RAM write bundle between game logic and the tile writer.
interface map_tile_writer_if
  import map_pkg::*;
();

  logic              req_valid;
  logic              req_ready;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic [ID_W-1:0]   req_id;
  logic              fill_req;
  logic              fill_ready;
  logic [COL_W-1:0]  fill_col;
  logic [ID_W-1:0]   fill_id;
  logic              map_we;
  logic [ADDR_W-1:0] map_waddr;
  logic [ID_W-1:0]   map_wdata;

  modport master (
    output req_valid, req_row, req_col, req_id, fill_req, fill_col, fill_id,
    input  req_ready, fill_ready, map_we, map_waddr, map_wdata
  );

  modport slave (
    input  req_valid, req_row, req_col, req_id, fill_req, fill_col, fill_id,
    output req_ready, fill_ready, map_we, map_waddr, map_wdata
  );

endinterface

// File: rtl/map_tile_writer_req_fifo.sv
// First-word-fall-through request FIFO; a push while full is dropped even if a pop occurs.
module map_req_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign last    = (count == (PTR_W+1)'(1));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/map_tile_writer.sv
// Buffers tile updates and column fills, committing them to the map RAM write port
// only inside the commit window (vertical blank by default).
module map_tile_writer
  import map_pkg::*;
#(
  parameter bit          BLANK_ONLY = 1'b1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  map_tile_writer_if.slave bus,
  input  logic             blank,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_ctr_q, row_ctr_d;
  logic [COL_W-1:0]  fcol_q, fcol_d;
  logic [ID_W-1:0]   fid_q, fid_d;
  logic              map_we_q, map_we_d;
  logic [ADDR_W-1:0] map_waddr_q, map_waddr_d;
  logic [ID_W-1:0]   map_wdata_q, map_wdata_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic       fifo_full, fifo_empty, fifo_last, fifo_pop;
  logic [REQ_W-1:0] fifo_rdata;
  req_t       push_req, head;
  logic       push_ok, commit_ok, err_inc;

  assign push_req  = '{row: bus.req_row, col: bus.req_col, id: bus.req_id};
  assign head      = req_t'(fifo_rdata);
  assign push_ok   = bus.req_valid && !fifo_full;
  assign commit_ok = blank || !BLANK_ONLY;

  map_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .wdata (push_req),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  assign bus.req_ready  = !fifo_full;
  assign bus.fill_ready = (state_q == IDLE);
  assign bus.map_we     = map_we_q;
  assign bus.map_waddr  = map_waddr_q;
  assign bus.map_wdata  = map_wdata_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;
  assign err_cnt        = err_cnt_q;

  // Next-state, write port and error accounting.
  always_comb begin
    state_d     = state_q;
    row_ctr_d   = row_ctr_q;
    fcol_d      = fcol_q;
    fid_d       = fid_q;
    map_we_d    = 1'b0;
    map_waddr_d = map_waddr_q;
    map_wdata_d = map_wdata_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.fill_req) begin
          if (bus.fill_col < COL_W'(MAP_COLS)) begin
            fcol_d    = bus.fill_col;
            fid_d     = bus.fill_id;
            row_ctr_d = '0;
            state_d   = FILL;
          end else begin
            err_inc = 1'b1;
          end
        end else if (!fifo_empty) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (commit_ok) begin
          fifo_pop = 1'b1;
          if (head.row < ROW_W'(MAP_ROWS) && head.col < COL_W'(MAP_COLS)) begin
            map_we_d    = 1'b1;
            map_waddr_d = tile_addr(head.row, head.col);
            map_wdata_d = head.id;
          end else begin
            err_inc = 1'b1;
          end
          if (fifo_last && !push_ok) state_d = IDLE;
        end
      end

      FILL: begin
        if (commit_ok) begin
          map_we_d    = 1'b1;
          map_waddr_d = tile_addr(row_ctr_q, fcol_q);
          map_wdata_d = fid_q;
          if (row_ctr_q == ROW_W'(MAP_ROWS - 1)) begin
            row_ctr_d = '0;
            state_d   = IDLE;
          end else begin
            row_ctr_d = row_ctr_q + ROW_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (err_inc && err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_ctr_q   <= '0;
      fcol_q      <= '0;
      fid_q       <= '0;
      map_we_q    <= 1'b0;
      map_waddr_q <= '0;
      map_wdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_ctr_q   <= row_ctr_d;
      fcol_q      <= fcol_d;
      fid_q       <= fid_d;
      map_we_q    <= map_we_d;
      map_waddr_q <= map_waddr_d;
      map_wdata_q <= map_wdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule
